onehot_regfile: RTL and testbench

Register bank that sits directly downstream of the cpu55 parameterised decoder and takes the decoder's one-hot output as its per-register write strobes. It holds NUM_REGS general registers, provides two synchronous read ports with write-first forwarding, and rejects illegal (multi-hot) strobe patterns. A sticky error flag and a saturating error counter record each rejected write.

---
 rtl/onehot_regfile.sv | 103 ++++++++++
 tb/tb_onehot_regfile.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/onehot_regfile.sv
// Register bank written through one-hot strobes from an upstream decoder.
// Two registered read ports with write-first forwarding; multi-hot strobes are rejected and counted.
module onehot_regfile #(
    parameter int unsigned SEL_WIDTH  = 3,
    // Fixed at 2**SEL_WIDTH so that every read address is in range
    parameter int unsigned NUM_REGS   = 2 ** SEL_WIDTH,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REGS-1:0]   we_onehot,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [SEL_WIDTH-1:0]  rd_addr_a,
    input  logic [SEL_WIDTH-1:0]  rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  rd_valid,
    output logic                  err_multi,
    output logic [7:0]            err_cnt
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_WIDTH-1:0] rd_data_b_q, rd_data_b_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  err_multi_q, err_multi_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic [NUM_REGS-1:0]   strobe_low_cleared;
    logic                  strobe_any;
    logic                  strobe_multi;
    logic                  wr_legal;
    logic                  fwd_a;
    logic                  fwd_b;

    // Clearing the lowest set bit leaves something behind only for two or more set bits
    assign strobe_low_cleared = we_onehot & (we_onehot - NUM_REGS'(1));
    assign strobe_any         = |we_onehot;
    assign strobe_multi       = |strobe_low_cleared;
    assign wr_legal           = strobe_any & ~strobe_multi;

    assign fwd_a = wr_legal & we_onehot[rd_addr_a];
    assign fwd_b = wr_legal & we_onehot[rd_addr_b];

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_legal && we_onehot[i]) begin
                regs_d[i] = wr_data;
            end
        end
    end

    always_comb begin
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        rd_valid_d  = rd_en;
        if (rd_en) begin
            rd_data_a_d = fwd_a ? wr_data : regs_q[rd_addr_a];
            rd_data_b_d = fwd_b ? wr_data : regs_q[rd_addr_b];
        end
    end

    always_comb begin
        err_multi_d = err_multi_q | strobe_multi;
        err_cnt_d   = err_cnt_q;
        if (strobe_multi && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rd_valid_q  <= 1'b0;
            err_multi_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            rd_valid_q  <= rd_valid_d;
            err_multi_q <= err_multi_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign rd_valid  = rd_valid_q;
    assign err_multi = err_multi_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_onehot_regfile.sv
// Self-checking bench for onehot_regfile: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_onehot_regfile;

    localparam int unsigned SEL_WIDTH  = 3;
    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned DATA_WIDTH = 16;

    logic                  clk;
    logic                  rst;
    logic [NUM_REGS-1:0]   we_onehot;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [SEL_WIDTH-1:0]  rd_addr_a;
    logic [SEL_WIDTH-1:0]  rd_addr_b;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [DATA_WIDTH-1:0] rd_data_b;
    logic                  rd_valid;
    logic                  err_multi;
    logic [7:0]            err_cnt;

    int checks   = 0;
    int failures = 0;

    onehot_regfile #(
        .SEL_WIDTH (SEL_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we_onehot(we_onehot),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b),
        .rd_valid (rd_valid),
        .err_multi(err_multi),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain array of register contents plus observable outputs
    logic [DATA_WIDTH-1:0] m_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] m_a, m_b;
    logic                  m_valid, m_err;
    int                    m_cnt;
    bit                    model_live = 0;

    always @(posedge clk) begin
        int pc;
        pc = $countones(we_onehot);
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
            m_a = '0; m_b = '0; m_valid = 0; m_err = 0; m_cnt = 0;
            model_live = 1;
        end else begin
            m_valid = rd_en;
            if (rd_en) begin
                m_a = (pc == 1 && we_onehot[rd_addr_a]) ? wr_data : m_regs[rd_addr_a];
                m_b = (pc == 1 && we_onehot[rd_addr_b]) ? wr_data : m_regs[rd_addr_b];
            end
            if (pc == 1) begin
                for (int i = 0; i < NUM_REGS; i++) if (we_onehot[i]) m_regs[i] = wr_data;
            end else if (pc >= 2) begin
                m_err = 1;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
            end
        end
        #1;
        if (model_live) begin
            check("model rd_valid", 32'(rd_valid), 32'(m_valid));
            check("model rd_data_a", 32'(rd_data_a), 32'(m_a));
            check("model rd_data_b", 32'(rd_data_b), 32'(m_b));
            check("model err_multi", 32'(err_multi), 32'(m_err));
            check("model err_cnt", 32'(err_cnt), 32'(m_cnt));
        end
    end

    // Apply one cycle of inputs, then settle past the edge and the model comparison
    task automatic drive(input logic r, input logic [NUM_REGS-1:0] we,
                         input logic [DATA_WIDTH-1:0] wd, input logic en,
                         input logic [SEL_WIDTH-1:0] a, input logic [SEL_WIDTH-1:0] b);
        rst = r; we_onehot = we; wr_data = wd; rd_en = en; rd_addr_a = a; rd_addr_b = b;
        @(posedge clk);
        #2;
    endtask

    task automatic read_pair(input logic [SEL_WIDTH-1:0] a, input logic [SEL_WIDTH-1:0] b);
        drive(0, '0, 16'h0, 1, a, b);
    endtask

    initial begin
        rst = 1; we_onehot = '0; wr_data = '0; rd_en = 0; rd_addr_a = '0; rd_addr_b = '0;
        @(negedge clk);

        // Reset state
        drive(1, '0, 16'h0, 0, 0, 0);
        read_pair(3'd0, 3'd7);
        check("reset rd_valid", 32'(rd_valid), 32'd1);
        check("reset rd_data_a", 32'(rd_data_a), 32'h0);
        check("reset rd_data_b", 32'(rd_data_b), 32'h0);
        check("reset err_multi", 32'(err_multi), 32'd0);
        check("reset err_cnt", 32'(err_cnt), 32'd0);

        // Walking write and readback
        for (int i = 0; i < 8; i++) drive(0, 8'(1 << i), 16'(16'h1000 + i), 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            read_pair(3'(i), 3'(7 - i));
            check("walk rd_valid", 32'(rd_valid), 32'd1);
            check("walk rd_data_a", 32'(rd_data_a), 32'(16'h1000 + i));
            check("walk rd_data_b", 32'(rd_data_b), 32'(16'h1007 - i));
        end
        drive(0, '0, 16'h0, 0, 0, 0);
        check("hold rd_valid", 32'(rd_valid), 32'd0);
        check("hold rd_data_a", 32'(rd_data_a), 32'h1007);

        // Reset coincident with read and write
        drive(1, 8'h02, 16'hBEEF, 1, 3'd1, 3'd1);
        check("rst-mid rd_valid", 32'(rd_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            read_pair(3'(i), 3'(i));
            check("rst-mid reg", 32'(rd_data_a), 32'h0);
        end
        check("rst-mid err_cnt", 32'(err_cnt), 32'd0);

        // Forwarding to both ports on the same register
        drive(0, 8'h08, 16'hAAAA, 0, 0, 0);
        drive(0, 8'h08, 16'h5555, 1, 3'd3, 3'd3);
        check("fwd rd_data_a", 32'(rd_data_a), 32'h5555);
        check("fwd rd_data_b", 32'(rd_data_b), 32'h5555);
        read_pair(3'd3, 3'd2);
        check("fwd later reg3", 32'(rd_data_a), 32'h5555);

        // Multi-hot strobe is suppressed and never forwarded
        drive(0, 8'h01, 16'h1111, 0, 0, 0);
        drive(0, 8'h10, 16'h4444, 0, 0, 0);
        drive(0, 8'h11, 16'hDEAD, 1, 3'd0, 3'd4);
        check("illegal rd_data_a", 32'(rd_data_a), 32'h1111);
        check("illegal rd_data_b", 32'(rd_data_b), 32'h4444);
        check("illegal err_multi", 32'(err_multi), 32'd1);
        check("illegal err_cnt", 32'(err_cnt), 32'd1);
        drive(0, 8'h00, 16'hDEAD, 0, 0, 0);
        check("idle err_cnt", 32'(err_cnt), 32'd1);

        // Saturation
        for (int i = 0; i < 300; i++) drive(0, 8'hFF, 16'($urandom), 0, 0, 0);
        check("sat err_cnt", 32'(err_cnt), 32'd255);
        drive(0, 8'hFF, 16'hFFFF, 0, 0, 0);
        check("sat hold err_cnt", 32'(err_cnt), 32'd255);
        check("sat err_multi", 32'(err_multi), 32'd1);
        read_pair(3'd0, 3'd4);
        check("sat reg0", 32'(rd_data_a), 32'h1111);
        check("sat reg4", 32'(rd_data_b), 32'h4444);

        // Randomized traffic checked by the model
        for (int n = 0; n < 3000; n++) begin
            logic [NUM_REGS-1:0] we;
            int kind;
            kind = $urandom_range(0, 3);
            if (kind == 0) we = '0;
            else if (kind == 3) we = 8'($urandom);
            else we = 8'(1 << $urandom_range(0, 7));
            drive(($urandom_range(0, 99) == 0), we, 16'($urandom), 1'($urandom),
                  3'($urandom), 3'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
